lattice_energy_eval: RTL and testbench



---
 rtl/lattice_eval_pkg.sv | 39 +++
 rtl/lattice_term_calc.sv | 57 +++++
 rtl/lattice_energy_eval.sv | 183 ++++++++++++++++++
 tb/tb_lattice_energy_eval.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/lattice_eval_pkg.sv
// ---------------------------------------------------------------------------
// lattice_eval_pkg
// Shared types and helpers for the lattice energy evaluator:
//   state_e  : evaluator FSM states (IDLE / ACC / DONE)
//   idx_width: bits needed to index a lattice of a given length
//   sat_add  : unsigned add that clamps at 2^width-1 and reports clamping
// ---------------------------------------------------------------------------
package lattice_eval_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Never returns 0 so a counter of this width always exists.
    function automatic int idx_width(input int len);
        int w;
        w = $clog2(len);
        if (w < 1) w = 1;
        return w;
    endfunction

    // Returns {saturated, sum}. Operands are assumed to already be below
    // 2^width, so the 33-bit intermediate cannot wrap.
    function automatic logic [32:0] sat_add(input logic [31:0] acc,
                                            input logic [31:0] term,
                                            input int unsigned  width);
        logic [32:0] sum;
        logic [32:0] max_v;
        sum   = {1'b0, acc} + {1'b0, term};
        max_v = (33'd1 << width) - 33'd1;
        if (sum > max_v) begin
            return {1'b1, max_v[31:0]};
        end
        return {1'b0, sum[31:0]};
    endfunction

endpackage

// File: rtl/lattice_term_calc.sv
// ---------------------------------------------------------------------------
// lattice_term_calc
// Combinational energy term for one lattice cell: self energy of the cell
// plus (optionally) the bond energy towards its right-hand neighbour.
// Ports:
//   t_i_i      : type of the current cell
//   t_next_i   : type of the neighbour cell
//   bond_en_i  : count the bond to the neighbour
//   s_vec_i    : self-energy vector, entry t at [t*EW +: EW]
//   j_mat_i    : interaction matrix, J[a][b] at [(a*N+b)*EW +: EW]
//   term_o     : S[t_i] + bond energy (invalid types contribute 0)
//   invalid_o  : current cell type is out of range
// ---------------------------------------------------------------------------
module lattice_term_calc #(
    parameter int NUM_PARTICLE_TYPE = 3,
    parameter int TYPE_WIDTH        = 2,
    parameter int ENERGY_WIDTH      = 4
) (
    input  logic [TYPE_WIDTH-1:0]                                      t_i_i,
    input  logic [TYPE_WIDTH-1:0]                                      t_next_i,
    input  logic                                                       bond_en_i,
    input  logic [NUM_PARTICLE_TYPE*ENERGY_WIDTH-1:0]                  s_vec_i,
    input  logic [NUM_PARTICLE_TYPE*NUM_PARTICLE_TYPE*ENERGY_WIDTH-1:0] j_mat_i,
    output logic [ENERGY_WIDTH:0]                                      term_o,
    output logic                                                       invalid_o
);

    logic                    cur_ok;
    logic                    nxt_ok;
    logic [ENERGY_WIDTH-1:0] s_sel;
    logic [ENERGY_WIDTH-1:0] j_sel;
    logic [ENERGY_WIDTH-1:0] bond;

    // Loop-based selection keeps out-of-range type codes from indexing
    // past the end of the operand vectors; they simply select nothing.
    always_comb begin
        cur_ok = (int'(t_i_i) < NUM_PARTICLE_TYPE);
        nxt_ok = (int'(t_next_i) < NUM_PARTICLE_TYPE);
        s_sel  = '0;
        j_sel  = '0;
        for (int t = 0; t < NUM_PARTICLE_TYPE; t++) begin
            if (int'(t_i_i) == t) s_sel = s_vec_i[t*ENERGY_WIDTH +: ENERGY_WIDTH];
        end
        for (int a = 0; a < NUM_PARTICLE_TYPE; a++) begin
            for (int b = 0; b < NUM_PARTICLE_TYPE; b++) begin
                if ((int'(t_i_i) == a) && (int'(t_next_i) == b)) begin
                    j_sel = j_mat_i[(a*NUM_PARTICLE_TYPE+b)*ENERGY_WIDTH +: ENERGY_WIDTH];
                end
            end
        end
        // A bond touching an invalid cell contributes nothing.
        bond      = (bond_en_i && cur_ok && nxt_ok) ? j_sel : '0;
        term_o    = {1'b0, s_sel} + {1'b0, bond};
        invalid_o = !cur_ok;
    end

endmodule

// File: rtl/lattice_energy_eval.sv
// ---------------------------------------------------------------------------
// lattice_energy_eval
// Sequential fitness evaluator for a 1-D lattice protein. Captures one
// individual with its self-energy vector and interaction matrix, then adds
// one cell term per cycle into a saturating accumulator.
// Ports:
//   clk_i, rst_n          : clock, asynchronous active-low reset
//   in_valid_i/in_ready_o : operand handshake (ready only in IDLE)
//   self_energy_vec_i     : N entries of ENERGY_WIDTH
//   interact_matrix_i     : N*N entries of ENERGY_WIDTH
//   individual_vec_i      : L cells of TYPE_WIDTH
//   out_valid_o/out_ready_i : result handshake
//   fit_o, sat_o, err_o   : total energy, saturation flag, invalid-type flag
// ---------------------------------------------------------------------------
module lattice_energy_eval
    import lattice_eval_pkg::*;
#(
    parameter int NUM_PARTICLE_TYPE = 3,
    parameter int TYPE_WIDTH        = 2,
    parameter int ENERGY_WIDTH      = 4,
    parameter int LATTICE_LENGTH    = 11,
    parameter int FIT_WIDTH         = 10,
    parameter int PERIODIC          = 0
) (
    input  logic                                                        clk_i,
    input  logic                                                        rst_n,
    input  logic                                                        in_valid_i,
    output logic                                                        in_ready_o,
    input  logic [NUM_PARTICLE_TYPE*ENERGY_WIDTH-1:0]                   self_energy_vec_i,
    input  logic [NUM_PARTICLE_TYPE*NUM_PARTICLE_TYPE*ENERGY_WIDTH-1:0] interact_matrix_i,
    input  logic [LATTICE_LENGTH*TYPE_WIDTH-1:0]                        individual_vec_i,
    output logic                                                        out_valid_o,
    input  logic                                                        out_ready_i,
    output logic [FIT_WIDTH-1:0]                                        fit_o,
    output logic                                                        sat_o,
    output logic                                                        err_o
);

    localparam int S_W   = NUM_PARTICLE_TYPE * ENERGY_WIDTH;
    localparam int J_W   = NUM_PARTICLE_TYPE * NUM_PARTICLE_TYPE * ENERGY_WIDTH;
    localparam int IND_W = LATTICE_LENGTH * TYPE_WIDTH;
    localparam int IDX_W = idx_width(LATTICE_LENGTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LATTICE_LENGTH - 1);

    state_e              state_q, state_d;
    logic [S_W-1:0]      s_q, s_d;
    logic [J_W-1:0]      j_q, j_d;
    logic [IND_W-1:0]    ind_q, ind_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    // Kept 32 bits wide to match sat_add; saturation keeps the bits above
    // FIT_WIDTH at zero.
    logic [31:0]         acc_q, acc_d;
    logic                sat_q, sat_d;
    logic                err_q, err_d;
    logic                out_valid_q, out_valid_d;
    logic [FIT_WIDTH-1:0] fit_q, fit_d;
    logic                sat_res_q, sat_res_d;
    logic                err_res_q, err_res_d;

    logic [IDX_W-1:0]        nxt_idx;
    logic [TYPE_WIDTH-1:0]   t_cur;
    logic [TYPE_WIDTH-1:0]   t_nxt;
    logic                    bond_en;
    logic [ENERGY_WIDTH:0]   term;
    logic                    term_invalid;
    logic [32:0]             add_res;

    // The right-hand neighbour of the last cell wraps to cell 0; that bond
    // only counts in periodic mode.
    always_comb begin
        nxt_idx = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        t_cur   = ind_q[int'(idx_q)   * TYPE_WIDTH +: TYPE_WIDTH];
        t_nxt   = ind_q[int'(nxt_idx) * TYPE_WIDTH +: TYPE_WIDTH];
        bond_en = (idx_q != LAST_IDX) || (PERIODIC != 0);
    end

    lattice_term_calc #(
        .NUM_PARTICLE_TYPE (NUM_PARTICLE_TYPE),
        .TYPE_WIDTH        (TYPE_WIDTH),
        .ENERGY_WIDTH      (ENERGY_WIDTH)
    ) u_term (
        .t_i_i     (t_cur),
        .t_next_i  (t_nxt),
        .bond_en_i (bond_en),
        .s_vec_i   (s_q),
        .j_mat_i   (j_q),
        .term_o    (term),
        .invalid_o (term_invalid)
    );

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        j_d         = j_q;
        ind_d       = ind_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        fit_d       = fit_q;
        sat_res_d   = sat_res_q;
        err_res_d   = err_res_q;
        add_res     = sat_add(acc_q, 32'(term), FIT_WIDTH);

        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    s_d     = self_energy_vec_i;
                    j_d     = interact_matrix_i;
                    ind_d   = individual_vec_i;
                    idx_d   = '0;
                    acc_d   = '0;
                    sat_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                acc_d = add_res[31:0];
                sat_d = sat_q | add_res[32];
                err_d = err_q | term_invalid;
                idx_d = nxt_idx;
                // Last cell: publish the result straight from the final sum so
                // fit_o keeps the previous result until this moment.
                if (idx_q == LAST_IDX) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    fit_d       = acc_d[FIT_WIDTH-1:0];
                    sat_res_d   = sat_d;
                    err_res_d   = err_d;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            j_q         <= '0;
            ind_q       <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            fit_q       <= '0;
            sat_res_q   <= 1'b0;
            err_res_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            j_q         <= j_d;
            ind_q       <= ind_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            fit_q       <= fit_d;
            sat_res_q   <= sat_res_d;
            err_res_q   <= err_res_d;
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = out_valid_q;
    assign fit_o       = fit_q;
    assign sat_o       = sat_res_q;
    assign err_o       = err_res_q;

endmodule

// File: tb/tb_lattice_energy_eval.sv
// Bench for lattice_energy_eval: three instances share the stimulus
//   a: defaults, b: PERIODIC=1, c: FIT_WIDTH=6
module tb_lattice_energy_eval;

    localparam int N  = 3;
    localparam int TW = 2;
    localparam int EW = 4;
    localparam int L  = 11;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid_i = 1'b0;
    logic out_ready_i = 1'b0;
    logic [N*EW-1:0]   s_vec = '0;
    logic [N*N*EW-1:0] j_mat = '0;
    logic [L*TW-1:0]   ind = '0;

    logic        rdy_a, rdy_b, rdy_c;
    logic        ov_a, ov_b, ov_c;
    logic [9:0]  fit_a, fit_b;
    logic [5:0]  fit_c;
    logic        sat_a, sat_b, sat_c;
    logic        err_a, err_b, err_c;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    lattice_energy_eval #(.PERIODIC(0), .FIT_WIDTH(10)) dut_a (
        .clk_i(clk_i), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(rdy_a),
        .self_energy_vec_i(s_vec), .interact_matrix_i(j_mat), .individual_vec_i(ind),
        .out_valid_o(ov_a), .out_ready_i(out_ready_i), .fit_o(fit_a), .sat_o(sat_a), .err_o(err_a));

    lattice_energy_eval #(.PERIODIC(1), .FIT_WIDTH(10)) dut_b (
        .clk_i(clk_i), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(rdy_b),
        .self_energy_vec_i(s_vec), .interact_matrix_i(j_mat), .individual_vec_i(ind),
        .out_valid_o(ov_b), .out_ready_i(out_ready_i), .fit_o(fit_b), .sat_o(sat_b), .err_o(err_b));

    lattice_energy_eval #(.PERIODIC(0), .FIT_WIDTH(6)) dut_c (
        .clk_i(clk_i), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(rdy_c),
        .self_energy_vec_i(s_vec), .interact_matrix_i(j_mat), .individual_vec_i(ind),
        .out_valid_o(ov_c), .out_ready_i(out_ready_i), .fit_o(fit_c), .sat_o(sat_c), .err_o(err_c));

    typedef struct {
        string             name;
        logic [L*TW-1:0]   ind;
        logic [N*EW-1:0]   s;
        logic [N*N*EW-1:0] j;
        int                fit_a;
        int                sat_a;
        int                err;
        int                fit_b;
        int                fit_c;
        int                sat_c;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Present operands for one edge; returns once the accept edge has passed.
    task automatic send(input logic [L*TW-1:0] iv, input logic [N*EW-1:0] sv,
                        input logic [N*N*EW-1:0] jv);
        ind = iv; s_vec = sv; j_mat = jv;
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid rises (bounded).
    task automatic wait_done(input string name, output int cycles);
        cycles = 0;
        while (!ov_a && cycles < 40) begin
            @(posedge clk_i); #1;
            cycles++;
        end
        chk({name, "_lat"}, cycles, L);
    endtask

    task automatic release_out(input string name);
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        chk({name, "_ov_clr"}, int'(ov_a), 0);
        chk({name, "_rdy_back"}, int'(rdy_a), 1);
    endtask

    initial begin
        int cyc;
        int prev_fit;
        logic [L*TW-1:0] tmp;

        // Vector 0: all type 0, S={1,2,3}, J all 1 -> 11 + 10 bonds
        vecs[0] = '{"all0", '0, 12'h321, 36'h111111111, 21, 0, 0, 22, 21, 0};
        // Vector 1: all type 2, S all 15, J all 15 -> 165+150=315; periodic 330
        for (int i = 0; i < L; i++) tmp[i*TW +: TW] = 2'd2;
        vecs[1] = '{"all2", tmp, 12'hFFF, 36'hFFFFFFFFF, 315, 0, 0, 330, 63, 1};
        // Vector 2: cell 5 invalid -> 10 self + 8 bonds; periodic bond 10-0 adds 1
        tmp = '0;
        tmp[5*TW +: TW] = 2'd3;
        vecs[2] = '{"inv5", tmp, 12'h321, 36'h111111111, 18, 0, 1, 19, 18, 0};
        // Vector 3: types i%3, J[a][b]=3a+b+1 -> S 21 + bonds 47 = 68;
        // periodic J[1][0]=4 -> 72; 6-bit instance clamps at 63
        for (int i = 0; i < L; i++) tmp[i*TW +: TW] = TW'(i % 3);
        vecs[3] = '{"mix", tmp, 12'h321, 36'h987654321, 68, 0, 0, 72, 63, 1};

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ov", int'(ov_a), 0);
        chk("rst_fit", int'(fit_a), 0);
        chk("rst_sat", int'(sat_a), 0);
        chk("rst_err", int'(err_a), 0);
        chk("rst_rdy", int'(rdy_a), 1);
        rst_n = 1'b1;
        @(posedge clk_i); #1;

        prev_fit = 0;
        for (int v = 0; v < 4; v++) begin
            send(vecs[v].ind, vecs[v].s, vecs[v].j);
            chk({vecs[v].name, "_rdy_busy"}, int'(rdy_a), 0);
            chk({vecs[v].name, "_fit_hold"}, int'(fit_a), prev_fit);
            wait_done(vecs[v].name, cyc);
            chk({vecs[v].name, "_fit_a"}, int'(fit_a), vecs[v].fit_a);
            chk({vecs[v].name, "_sat_a"}, int'(sat_a), vecs[v].sat_a);
            chk({vecs[v].name, "_err_a"}, int'(err_a), vecs[v].err);
            chk({vecs[v].name, "_fit_b"}, int'(fit_b), vecs[v].fit_b);
            chk({vecs[v].name, "_ov_b"}, int'(ov_b), 1);
            chk({vecs[v].name, "_fit_c"}, int'(fit_c), vecs[v].fit_c);
            chk({vecs[v].name, "_sat_c"}, int'(sat_c), vecs[v].sat_c);
            chk({vecs[v].name, "_err_c"}, int'(err_c), vecs[v].err);
            release_out(vecs[v].name);
            prev_fit = vecs[v].fit_a;
        end

        // Back-pressure: result held, operand pulses ignored.
        send(vecs[0].ind, vecs[0].s, vecs[0].j);
        wait_done("bp", cyc);
        for (int k = 0; k < 5; k++) begin
            ind = vecs[1].ind; s_vec = vecs[1].s; j_mat = vecs[1].j;
            in_valid_i = (k % 2 == 0);
            @(posedge clk_i); #1;
            chk("bp_ov", int'(ov_a), 1);
            chk("bp_fit", int'(fit_a), 21);
            chk("bp_rdy", int'(rdy_a), 0);
        end
        in_valid_i = 1'b0;
        release_out("bp");
        @(posedge clk_i); #1;
        chk("bp_no_restart", int'(rdy_a), 1);

        // Reset in the middle of accumulation (idx=4).
        send(vecs[0].ind, vecs[0].s, vecs[0].j);
        repeat (4) @(posedge clk_i);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_ov", int'(ov_a), 0);
        chk("mrst_fit", int'(fit_a), 0);
        chk("mrst_rdy", int'(rdy_a), 1);
        @(posedge clk_i); #1;
        rst_n = 1'b1;
        @(posedge clk_i); #1;
        send(vecs[0].ind, vecs[0].s, vecs[0].j);
        wait_done("post_rst", cyc);
        chk("post_rst_fit", int'(fit_a), 21);
        chk("post_rst_err", int'(err_a), 0);
        release_out("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
